// File: rtl/imm_decode_pipe.sv
// Registered RV immediate decoder with a valid/ready input, a 2-entry skid buffer
// and a saturating count of delivered results.
module imm_decode_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] decode_count
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_decode_pipe: XLEN must be 32 or 64");
  end

  localparam logic [2:0] TYPE_NONE   = 3'd0;
  localparam logic [2:0] TYPE_I      = 3'd1;
  localparam logic [2:0] TYPE_ISHIFT = 3'd2;
  localparam logic [2:0] TYPE_S      = 3'd3;
  localparam logic [2:0] TYPE_B      = 3'd4;
  localparam logic [2:0] TYPE_U      = 3'd5;
  localparam logic [2:0] TYPE_J      = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       ty;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           dec;
  entry_t           out_q, out_d, skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      ext;
  logic             accept, out_fire;

  // Immediates are built at 64 bits and truncated, so one decode serves both XLENs.
  // NOTE: every always_comb output gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    ext         = '0;
    dec.ty      = TYPE_NONE;
    dec.illegal = 1'b0;
    dec.tag     = in_tag;
    case (in_instr[6:0])
      7'b0010011: begin
        if (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101) begin
          dec.ty      = TYPE_ISHIFT;
          ext         = (XLEN == 64) ? {58'd0, in_instr[25:20]} : {59'd0, in_instr[24:20]};
          dec.illegal = (XLEN == 32) && in_instr[25];
        end else begin
          dec.ty = TYPE_I;
          ext    = {{52{in_instr[31]}}, in_instr[31:20]};
        end
      end
      7'b0000011, 7'b1100111: begin
        dec.ty = TYPE_I;
        ext    = {{52{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec.ty = TYPE_S;
        ext    = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec.ty = TYPE_B;
        ext    = {{51{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.ty = TYPE_U;
        ext    = {{32{in_instr[31]}}, in_instr[31:12], 12'd0};
      end
      7'b1101111: begin
        dec.ty = TYPE_J;
        ext    = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = ext[XLEN-1:0];
  end

  assign accept   = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  // The output slot frees when empty or draining; a held output diverts new
  // entries to the skid, which in turn refills the output before new input can.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    count_d      = count_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    if (out_fire && count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      count_q      <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
      count_q      <= count_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_imm      = out_q.imm;
  assign out_type     = out_q.ty;
  assign out_illegal  = out_q.illegal;
  assign out_tag      = out_q.tag;
  assign decode_count = count_q;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Bench for imm_decode_pipe: XLEN=32 (3-bit counter) and XLEN=64 instances share
// one input stream and are compared against a queue-based reference model.
module tb_imm_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [3:0]  in_tag = '0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [2:0]  out_type32;
  logic [3:0]  out_tag32;
  logic [2:0]  cnt32;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [2:0]  out_type64;
  logic [3:0]  out_tag64;
  logic [15:0] cnt64;

  imm_decode_pipe #(.XLEN(32), .TAG_W(4), .CNT_W(3)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_type(out_type32),
    .out_illegal(out_illegal32), .out_tag(out_tag32), .decode_count(cnt32)
  );

  imm_decode_pipe #(.XLEN(64), .TAG_W(4), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_type(out_type64),
    .out_illegal(out_illegal64), .out_tag(out_tag64), .decode_count(cnt64)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  tag;
  } txn_t;

  txn_t       q[$];
  logic [3:0] popped[$];
  int         vectors = 0;
  int         errors  = 0;
  int         exp_cnt32 = 0;
  int         exp_cnt64 = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Reference decode from the format rules, using signed integer arithmetic.
  function automatic void ref_dec(input logic [31:0] i, input int xlen,
                                  output logic [63:0] imm, output logic [2:0] ty,
                                  output logic il);
    longint v = 0;
    logic [2:0] f3 = i[14:12];
    il = 1'b0;
    case (i[6:0])
      7'h13: if (f3 == 3'd1 || f3 == 3'd5) begin
               ty = 3'd2;
               v  = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
               il = (xlen == 32) && i[25];
             end else begin
               ty = 3'd1; v = longint'($signed(i[31:20]));
             end
      7'h03, 7'h67: begin ty = 3'd1; v = longint'($signed(i[31:20])); end
      7'h23: begin ty = 3'd3; v = longint'($signed({i[31:25], i[11:7]})); end
      7'h63: begin ty = 3'd4; v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
      7'h37, 7'h17: begin ty = 3'd5; v = longint'($signed(i & 32'hFFFFF000)); end
      7'h6F: begin ty = 3'd6; v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      default: begin ty = 3'd0; il = 1'b1; v = 0; end
    endcase
    imm = (xlen == 32) ? {32'd0, v[31:0]} : 64'(v);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [0:9];
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 10);
    ops = '{7'h13, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    return {r[31:7], (k == 10) ? r[6:0] : ops[k]};
  endfunction

  // One cycle: drive at the falling edge, check flop outputs, advance the model.
  task automatic tick(input bit iv, input logic [31:0] ins, input logic [3:0] tg,
                      input bit ordy, output bit acc);
    logic [63:0] e_imm;
    logic [2:0]  e_ty;
    logic        e_il;
    @(negedge clk);
    in_valid = iv; in_instr = ins; in_tag = tg; out_ready = ordy;
    #1;
    check("in_ready32", in_ready32, q.size() < 2);
    check("in_ready64", in_ready64, q.size() < 2);
    check("out_valid32", out_valid32, q.size() > 0);
    check("out_valid64", out_valid64, q.size() > 0);
    check("count32", cnt32, exp_cnt32);
    check("count64", cnt64, exp_cnt64);
    if (q.size() > 0) begin
      ref_dec(q[0].instr, 32, e_imm, e_ty, e_il);
      check("imm32", out_imm32, e_imm);
      check("type32", out_type32, e_ty);
      check("illegal32", out_illegal32, e_il);
      check("tag32", out_tag32, q[0].tag);
      ref_dec(q[0].instr, 64, e_imm, e_ty, e_il);
      check("imm64", out_imm64, e_imm);
      check("type64", out_type64, e_ty);
      check("illegal64", out_illegal64, e_il);
      check("tag64", out_tag64, q[0].tag);
    end
    acc = iv && (q.size() < 2);
    if (q.size() > 0 && ordy) begin
      popped.push_back(q[0].tag);
      void'(q.pop_front());
      if (exp_cnt32 < 7) exp_cnt32++;
      exp_cnt64++;
    end
    if (acc) q.push_back('{ins, tg});
  endtask

  task automatic drain();
    bit acc;
    for (int n = 0; n < 10 && q.size() > 0; n++) tick(1'b0, '0, '0, 1'b1, acc);
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int sent;
    logic [31:0] directed [0:8];
    directed = '{32'h00A01013, 32'h02A01013, 32'hFC000CE3, 32'hFFF9C037, 32'h0000007F,
                 32'hFE112E23, 32'h8000006F, 32'h00000517, 32'h41F6D093};

    #12;
    check("rst_out_valid32", out_valid32, 0);
    check("rst_in_ready32", in_ready32, 1);
    check("rst_imm32", out_imm32, 0);
    check("rst_type64", out_type64, 0);
    check("rst_illegal64", out_illegal64, 0);
    check("rst_tag64", out_tag64, 0);
    check("rst_count64", cnt64, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // addi -3 with the consumer always ready.
    tick(1'b1, 32'hFFD00093, 4'd5, 1'b1, acc);
    tick(1'b0, '0, '0, 1'b1, acc);
    check("tp_addi_imm32", out_imm32, 32'hFFFFFFFD);
    check("tp_addi_imm64", out_imm64, 64'hFFFFFFFFFFFFFFFD);
    check("tp_addi_type", out_type32, 1);
    tick(1'b0, '0, '0, 1'b1, acc);
    check("tp_addi_count", cnt64, 1);

    foreach (directed[k]) tick(1'b1, directed[k], 4'(k), 1'b1, acc);
    drain();

    // Four back-to-back requests against a stalled consumer.
    popped.delete();
    sent = 0;
    for (int n = 0; n < 4; n++) begin
      tick(1'b1, rand_instr(), 4'(sent + 1), 1'b0, acc);
      if (acc) sent++;
    end
    check("bp_accepts", sent, 2);
    check("bp_in_ready_low", in_ready64, 0);
    for (int n = 0; n < 20 && (sent < 4 || q.size() > 0); n++) begin
      tick(sent < 4, rand_instr(), 4'(sent + 1), 1'b1, acc);
      if (acc) sent++;
    end
    check("bp_all_sent", sent, 4);
    check("bp_order", {popped[0], popped[1], popped[2], popped[3]}, 16'h1234);
    check("bp_pop_count", popped.size(), 4);

    // Random traffic with random backpressure.
    for (int n = 0; n < 400; n++)
      tick($urandom_range(0, 3) != 0, rand_instr(), 4'($urandom), $urandom_range(0, 3) != 0, acc);
    drain();
    check("count32_saturated", cnt32, 7);

    // Fill the skid, then reset asynchronously mid-cycle.
    tick(1'b1, 32'h00A01013, 4'd9, 1'b0, acc);
    tick(1'b1, 32'hFC000CE3, 4'd10, 1'b0, acc);
    tick(1'b0, '0, '0, 1'b0, acc);
    check("skid_full_ready", in_ready32, 0);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("arst_out_valid32", out_valid32, 0);
    check("arst_out_valid64", out_valid64, 0);
    check("arst_in_ready32", in_ready32, 1);
    check("arst_in_ready64", in_ready64, 1);
    check("arst_count32", cnt32, 0);
    check("arst_count64", cnt64, 0);
    q.delete();
    exp_cnt32 = 0;
    exp_cnt64 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 32'hFFF9C037, 4'd3, 1'b1, acc);
    tick(1'b0, '0, '0, 1'b1, acc);
    check("post_rst_imm32", out_imm32, 32'hFFF9C000);
    check("post_rst_type", out_type64, 5);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/imm_decode_pipe.md
Name: imm_decode_pipe

Overview:
- Parametrised, registered successor to the combinational immediate generator.
- Accepts a stream of 32-bit RV instructions over valid/ready and classifies the format from the opcode.
- Emits one sign-/zero-extended XLEN-wide immediate per instruction with a type code, an illegal flag and a passthrough tag.
- Sits between fetch and the register-read stage; a 2-entry skid buffer provides full throughput under backpressure.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64
TAG_W, 4, width of sideband tag carried alongside each instruction
CNT_W, 16, width of the saturating decoded-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction present on in_instr
in_ready  out  1  block can accept an instruction this cycle
in_instr  in  32  raw instruction word
in_tag  in  TAG_W  sideband tag, returned unchanged
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
out_imm  out  XLEN  extended immediate
out_type  out  3  0 NONE, 1 I, 2 ISHIFT, 3 S, 4 B, 5 U, 6 J
out_illegal  out  1  opcode or shift encoding not supported
out_tag  out  TAG_W  tag of this result
decode_count  out  CNT_W  results delivered since reset, saturating

Behaviour:
- Reset (async assert, sync release): out_valid=0, in_ready=1, out_imm=0, out_type=0, out_illegal=0, out_tag=0, decode_count=0, skid empty. Asserting reset mid-transfer discards all held entries.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_* must stay stable while out_valid && !out_ready.
- Latency: exactly 1 cycle from input transfer to out_valid when the output register is empty or draining.
- Storage: output register plus one skid entry.
  - in_ready = !skid_valid, driven from a flop with no combinational path from out_ready.
  - Accept while the output is held (out_valid && !out_ready) -> entry goes to skid.
  - Output transfer with skid full -> skid moves to output; in_ready rises next cycle.
  - Simultaneous accept and output transfer with skid empty -> new entry goes straight to output.
- Decode, by opcode = instr[6:0]:
  - 0010011 with funct3 001/101 -> ISHIFT: imm = zero-extended shamt, instr[24:20] for XLEN=32, instr[25:20] for XLEN=64.
  - XLEN=32 and instr[25]=1 on a shift -> illegal.
  - 0010011 (other funct3), 0000011, 1100111 -> I: sext(instr[31:20]).
  - 0100011 -> S: sext({instr[31:25],instr[11:7]}).
  - 1100011 -> B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - 0110111, 0010111 -> U: sext({instr[31:12],12'b0}); upper bits copy instr[31] for XLEN=64.
  - 1101111 -> J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - Anything else -> type NONE, illegal=1, imm=0.
- All sign extension is to XLEN from the instr[31] sign bit.
- decode_count increments on each output transfer and holds at 2^CNT_W-1; illegal results are counted.
- Unsupported XLEN values are an elaboration error.

Test Plan:
- XLEN=32: in_instr=0xFFD00093 (addi -3), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFD, out_type=1, out_illegal=0, decode_count=1.
- Shift and illegal shift:
  - 0x00A01013 -> out_imm=0x0000000A, type=2.
  - 0x02A01013 at XLEN=32 -> illegal=1.
  - 0x02A01013 at XLEN=64 -> out_imm=0x2A, illegal=0.
- Other formats:
  - B 0xFC000CE3 -> out_imm=0xFFFFFFD8 (-40), type=4.
  - U 0xFFF9C037 -> out_imm=0xFFF9C000, type=5.
  - XLEN=64 addi 0xFFD00093 -> out_imm=0xFFFFFFFFFFFFFFFD.
- Backpressure:
  - Drive 4 back-to-back instructions, tags 1..4, with out_ready=0 -> in_ready drops after 2 accepts; outputs stay stable.
  - Then out_ready=1 -> tags emerge 1,2,3,4 in order with no loss or duplication.
- Illegal opcode: 0x0000007F -> out_type=0, out_illegal=1, out_imm=0, decode_count still increments.
- Reset mid-operation: pulse rst_n low asynchronously with skid full -> out_valid=0, in_ready=1, decode_count=0 immediately; the next instruction decodes normally.
